// File: rtl/cu_command_arbiter_pkg.sv
// CAPI port bundles and tag helpers shared by the
// command arbiter and its round-robin picker.
package cu_command_arbiter_pkg;

  localparam int NUM_WE_MAX = 16;
  localparam int TAG_W      = 8;

  typedef enum logic [12:0] {
    CMD_READ_CL_NA = 13'h0A00,
    CMD_WRITE_NA   = 13'h0D00
  } cmd_e;

  typedef struct packed {
    logic        valid;
    logic [12:0] command;
    logic        command_parity;
    logic [7:0]  tag;
    logic        tag_parity;
    logic [11:0] size;
    logic [63:0] address;
    logic        address_parity;
    logic [2:0]  abt;
    logic [15:0] context_handle;
  } CommandInterfaceOutput;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic       tag_parity;
    logic [7:0] response;
    logic [8:0] credits;
  } ResponseInterface;

  typedef struct packed {
    logic         write_valid;
    logic [7:0]   write_tag;
    logic         write_tag_parity;
    logic [5:0]   write_address;
    logic [511:0] write_data;
    logic [7:0]   write_parity;
    logic         read_valid;
    logic [7:0]   read_tag;
    logic         read_tag_parity;
    logic [5:0]   read_address;
  } BufferInterfaceInput;

  typedef struct packed {
    logic [3:0]   read_latency;
    logic [511:0] read_data;
    logic         read_parity;
  } BufferInterfaceOutput;

  // Idle command word: zero fields carry odd parity of 1.
  localparam CommandInterfaceOutput CMD_IDLE = '{
    command_parity: 1'b1,
    tag_parity:     1'b1,
    address_parity: 1'b1,
    default:        '0
  };

  function automatic logic [7:0] tag_owner(
    input logic [7:0] tag,
    input int         id_bits
  );
    return tag >> (TAG_W - id_bits);
  endfunction

  function automatic logic [7:0] tag_restore(
    input logic [7:0] tag,
    input int         id_bits
  );
    return tag & (8'hFF >> id_bits);
  endfunction

endpackage

// File: rtl/cu_command_arbiter_rr_arbiter.sv
// Rotating-priority picker: first request at or after
// the pointer wins; pointer advances past the winner.
module cu_command_arbiter_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o,
  output logic          gnt_vld_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin : pick
    int idx;
    gnt_o     = '0;
    gnt_id_o  = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    if (en_i) begin
      for (int i = 0; i < N; i++) begin
        idx = (int'(ptr_q) + i) % N;
        if (!gnt_vld_o && req_i[IW'(idx)]) begin
          gnt_vld_o          = 1'b1;
          gnt_o[IW'(idx)]    = 1'b1;
          gnt_id_o           = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_o) begin
      if (int'(gnt_id_o) == N - 1) ptr_d = '0;
      else ptr_d = gnt_id_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cu_command_arbiter.sv
// Shares one PSL command/response/buffer port among
// NUM_WE work elements; requester id rides in tag MSBs.
module cu_command_arbiter
  import cu_command_arbiter_pkg::*;
#(
  parameter int NUM_WE       = 4,
  parameter int ID_BITS      = 2,
  parameter int INIT_CREDITS = 64
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  CommandInterfaceOutput [NUM_WE-1:0]  we_cmd,
  output logic                  [NUM_WE-1:0]  we_cmd_ack,
  output CommandInterfaceOutput               cmd_out,
  input  ResponseInterface                    response_in,
  output ResponseInterface      [NUM_WE-1:0]  we_response,
  input  BufferInterfaceInput                 buffer_in,
  output BufferInterfaceInput   [NUM_WE-1:0]  we_buffer_in,
  input  BufferInterfaceOutput  [NUM_WE-1:0]  we_buffer_out,
  output BufferInterfaceOutput                buffer_out
);

  localparam int IW = (NUM_WE > 1) ? $clog2(NUM_WE) : 1;
  localparam int CW = 10;
  localparam logic [CW-1:0] CR_INIT = CW'(INIT_CREDITS);

  logic [NUM_WE-1:0] req, gnt;
  logic [IW-1:0]     gnt_id;
  logic              issue, arb_en;
  logic [7:0]        gnt_tag;

  CommandInterfaceOutput cmd_q, cmd_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic [CW:0]           cr_sum;

  logic [7:0]   rsp_own, wr_own, rd_own;
  logic         rd_hit;
  logic         rd_vld_q;
  logic [IW-1:0] rd_own_q, rd_own_d;
  logic [511:0] rdata_q, rdata_d;
  logic         unused;

  always_comb begin
    for (int i = 0; i < NUM_WE; i++) req[i] = we_cmd[i].valid;
  end

  // Reset gates the grant so acks drop the moment reset_n falls.
  assign arb_en = reset_n && (credits_q != '0);

  cu_command_arbiter_rr_arbiter #(.N(NUM_WE)) u_rr (
    .clk       (clock),
    .rst_n     (reset_n),
    .req_i     (req),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .gnt_vld_o (issue)
  );

  assign we_cmd_ack = gnt;

  always_comb begin
    gnt_tag = (8'(gnt_id) << (TAG_W - ID_BITS))
            | tag_restore(we_cmd[gnt_id].tag, ID_BITS);
    cmd_d = CMD_IDLE;
    if (issue) begin
      cmd_d.valid   = 1'b1;
      cmd_d.command = we_cmd[gnt_id].command;
      cmd_d.tag     = gnt_tag;
      cmd_d.size    = we_cmd[gnt_id].size;
      cmd_d.address = we_cmd[gnt_id].address;
    end
    cmd_d.command_parity = ~^cmd_d.command;
    cmd_d.tag_parity     = ~^cmd_d.tag;
    cmd_d.address_parity = ~^cmd_d.address;
  end

  always_comb begin
    cr_sum = {1'b0, credits_q} - (CW+1)'(issue);
    if (response_in.valid)
      cr_sum = cr_sum + (CW+1)'(response_in.credits);
    if (cr_sum > (CW+1)'(INIT_CREDITS)) credits_d = CR_INIT;
    else credits_d = cr_sum[CW-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q     <= CMD_IDLE;
      credits_q <= CR_INIT;
    end else begin
      cmd_q     <= cmd_d;
      credits_q <= credits_d;
    end
  end

  assign cmd_out = cmd_q;

  assign rsp_own = tag_owner(response_in.tag, ID_BITS);
  assign wr_own  = tag_owner(buffer_in.write_tag, ID_BITS);
  assign rd_own  = tag_owner(buffer_in.read_tag, ID_BITS);

  always_comb begin
    for (int i = 0; i < NUM_WE; i++) begin
      we_response[i]       = response_in;
      we_response[i].valid = reset_n && response_in.valid
                          && (rsp_own == 8'(i));
      we_response[i].tag   = tag_restore(response_in.tag, ID_BITS);
      we_response[i].tag_parity = ~^we_response[i].tag;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_WE; i++) begin
      we_buffer_in[i] = buffer_in;
      we_buffer_in[i].write_valid = reset_n && buffer_in.write_valid
                                 && (wr_own == 8'(i));
      we_buffer_in[i].write_tag =
        tag_restore(buffer_in.write_tag, ID_BITS);
      we_buffer_in[i].write_tag_parity = ~^we_buffer_in[i].write_tag;
      we_buffer_in[i].read_valid = reset_n && buffer_in.read_valid
                                && (rd_own == 8'(i));
      we_buffer_in[i].read_tag =
        tag_restore(buffer_in.read_tag, ID_BITS);
      we_buffer_in[i].read_tag_parity = ~^we_buffer_in[i].read_tag;
    end
  end

  // Owner id travels one stage while the requester fetches its data.
  assign rd_hit   = reset_n && buffer_in.read_valid
                 && (rd_own < 8'(NUM_WE));
  assign rd_own_d = rd_own[IW-1:0];
  assign rdata_d  = rd_vld_q ? we_buffer_out[rd_own_q].read_data : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q <= 1'b0;
      rd_own_q <= '0;
      rdata_q  <= '0;
    end else begin
      rd_vld_q <= rd_hit;
      rd_own_q <= rd_own_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    buffer_out.read_latency = 4'd2;
    buffer_out.read_data    = rdata_q;
    buffer_out.read_parity  = ~^rdata_q;
  end

  always_comb begin
    unused = ^{response_in.tag_parity,
               buffer_in.write_tag_parity,
               buffer_in.read_tag_parity};
    for (int i = 0; i < NUM_WE; i++) begin
      unused = unused ^ ^{we_cmd[i].command_parity,
                          we_cmd[i].tag_parity,
                          we_cmd[i].address_parity,
                          we_cmd[i].abt,
                          we_cmd[i].context_handle,
                          we_buffer_out[i].read_latency,
                          we_buffer_out[i].read_parity};
    end
  end

endmodule

// File: tb/tb_cu_command_arbiter.sv
// Directed bench for cu_command_arbiter with tag and
// read-data scoreboards; second instance runs low credits.
module tb_cu_command_arbiter;
  import cu_command_arbiter_pkg::*;
  timeunit 1ns;
  timeprecision 1ps;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  CommandInterfaceOutput [3:0] we_cmd, we_cmd2;
  logic [3:0]                  ack, ack2;
  CommandInterfaceOutput       cmd_out, cmd_out2;
  ResponseInterface            rsp, rsp2;
  ResponseInterface [3:0]      we_rsp, we_rsp2;
  BufferInterfaceInput         buf_in, buf_in2;
  BufferInterfaceInput [3:0]   we_buf_in, we_buf_in2;
  BufferInterfaceOutput [3:0]  we_buf_out, we_buf_out2;
  BufferInterfaceOutput        buf_out, buf_out2;

  cu_command_arbiter dut (
    .clock         (clk),
    .reset_n       (rst_n),
    .we_cmd        (we_cmd),
    .we_cmd_ack    (ack),
    .cmd_out       (cmd_out),
    .response_in   (rsp),
    .we_response   (we_rsp),
    .buffer_in     (buf_in),
    .we_buffer_in  (we_buf_in),
    .we_buffer_out (we_buf_out),
    .buffer_out    (buf_out)
  );

  cu_command_arbiter #(.INIT_CREDITS(2)) dut2 (
    .clock         (clk),
    .reset_n       (rst_n),
    .we_cmd        (we_cmd2),
    .we_cmd_ack    (ack2),
    .cmd_out       (cmd_out2),
    .response_in   (rsp2),
    .we_response   (we_rsp2),
    .buffer_in     (buf_in2),
    .we_buffer_in  (we_buf_in2),
    .we_buffer_out (we_buf_out2),
    .buffer_out    (buf_out2)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]   tag_q[$];
  logic [511:0] rd_q[$];

  task automatic chk(input string tg,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
    end
  endtask

  task automatic pop_cmd(input string tg,
                         input CommandInterfaceOutput c);
    logic [7:0] e;
    chk({tg, "_valid"}, 64'(c.valid), 64'd1);
    chk({tg, "_sbdepth"}, 64'(tag_q.size()), 64'd1);
    if (tag_q.size() != 0) begin
      e = tag_q.pop_front();
      chk({tg, "_tag"}, 64'(c.tag), 64'(e));
      chk({tg, "_tpar"}, 64'(c.tag_parity), 64'(~^e));
    end
  endtask

  task automatic pop_rd(input string tg);
    logic [511:0] e;
    chk({tg, "_sbdepth"}, 64'(rd_q.size()), 64'd1);
    if (rd_q.size() != 0) begin
      e = rd_q.pop_front();
      checks++;
      assert (buf_out.read_data === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h",
               tg, buf_out.read_data, e);
      end
      chk({tg, "_par"}, 64'(buf_out.read_parity), 64'(~^e));
    end
  endtask

  function automatic CommandInterfaceOutput mk(input logic [7:0] t);
    mk         = '0;
    mk.valid   = 1'b1;
    mk.command = CMD_READ_CL_NA;
    mk.tag     = t;
    mk.size    = 12'd128;
    mk.address = {48'h0, t, 8'h00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] et;
    int id;
    we_cmd = '0; we_cmd2 = '0;
    rsp = '0; rsp2 = '0;
    buf_in = '0; buf_in2 = '0;
    we_buf_out = '0; we_buf_out2 = '0;
    rst_n = 1'b0;
    tick();
    chk("rst_cvalid", 64'(cmd_out.valid), 64'd0);
    chk("rst_tpar", 64'(cmd_out.tag_parity), 64'd1);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rdata", buf_out.read_data[63:0], 64'd0);
    chk("rst_rlat", 64'(buf_out.read_latency), 64'd2);
    tick();
    rst_n = 1'b1;

    // single requester
    we_cmd[0] = mk(8'h01);
    #1;
    chk("one_ack", 64'(ack), 64'b0001);
    tag_q.push_back(8'h01);
    tick();
    we_cmd[0].valid = 1'b0;
    pop_cmd("one", cmd_out);
    chk("one_cmd", 64'(cmd_out.command), 64'(CMD_READ_CL_NA));
    chk("one_addr", cmd_out.address, 64'h100);
    chk("one_cpar", 64'(cmd_out.command_parity),
        64'(~^CMD_READ_CL_NA));
    #1;
    chk("one_ack_drop", 64'(ack), 64'd0);
    tick();
    chk("one_idle", 64'(cmd_out.valid), 64'd0);

    // reset in flight
    we_cmd[2] = mk(8'h03);
    #1;
    chk("mr_ack", 64'(ack), 64'b0100);
    tag_q.push_back(8'h83);
    tick();
    pop_cmd("mr", cmd_out);
    rst_n = 1'b0;
    rsp = '{valid: 1'b1, tag: 8'h81, tag_parity: 1'b0,
            response: 8'h0, credits: 9'd1};
    #1;
    chk("mr_cvalid", 64'(cmd_out.valid), 64'd0);
    chk("mr_ack0", 64'(ack), 64'd0);
    chk("mr_rsp", 64'(we_rsp[2].valid), 64'd0);
    tag_q.delete();
    tick();
    rsp.valid = 1'b0;
    tick();
    we_cmd[2].valid = 1'b0;
    rst_n = 1'b1;

    // all four requesters, pointer restarts at 0
    for (int i = 0; i < 4; i++) we_cmd[i] = mk(8'(i + 4));
    for (int k = 0; k < 5; k++) begin
      id = k % 4;
      et = (8'(id) << 6) | 8'(id + 4);
      #1;
      chk($sformatf("rr_ack%0d", k), 64'(ack), 64'(4'b1 << id));
      tag_q.push_back(et);
      tick();
      pop_cmd($sformatf("rr%0d", k), cmd_out);
    end
    we_cmd = '0;
    #1;
    chk("rr_ack_end", 64'(ack), 64'd0);
    tick();
    chk("rr_idle", 64'(cmd_out.valid), 64'd0);

    // response routing
    rsp = '{valid: 1'b1, tag: 8'h81, tag_parity: 1'b1,
            response: 8'h0, credits: 9'd1};
    #1;
    chk("rsp2_vec", 64'({we_rsp[3].valid, we_rsp[2].valid,
                        we_rsp[1].valid, we_rsp[0].valid}), 64'b0100);
    chk("rsp2_tag", 64'(we_rsp[2].tag), 64'h01);
    chk("rsp2_tpar", 64'(we_rsp[2].tag_parity), 64'd0);
    rsp.tag = 8'hC5;
    #1;
    chk("rsp3_vec", 64'({we_rsp[3].valid, we_rsp[2].valid,
                        we_rsp[1].valid, we_rsp[0].valid}), 64'b1000);
    chk("rsp3_tag", 64'(we_rsp[3].tag), 64'h05);
    tick();
    rsp.valid = 1'b0;

    // buffer write fan-out
    buf_in.write_valid   = 1'b1;
    buf_in.write_tag     = 8'h47;
    buf_in.write_address = 6'd5;
    buf_in.write_data    = {16{32'hDEADBEEF}};
    #1;
    chk("wr_vec", 64'({we_buf_in[3].write_valid,
                      we_buf_in[2].write_valid,
                      we_buf_in[1].write_valid,
                      we_buf_in[0].write_valid}), 64'b0010);
    chk("wr_tag", 64'(we_buf_in[1].write_tag), 64'h07);
    chk("wr_addr", 64'(we_buf_in[1].write_address), 64'd5);
    chk("wr_data", we_buf_in[1].write_data[63:0],
        64'hDEADBEEF_DEADBEEF);
    tick();
    buf_in.write_valid = 1'b0;

    // back-to-back reads: id 1 then id 3
    buf_in.read_valid   = 1'b1;
    buf_in.read_tag     = 8'h40;
    buf_in.read_address = 6'd1;
    #1;
    chk("rd1_vec", 64'({we_buf_in[3].read_valid,
                       we_buf_in[2].read_valid,
                       we_buf_in[1].read_valid,
                       we_buf_in[0].read_valid}), 64'b0010);
    chk("rd1_tag", 64'(we_buf_in[1].read_tag), 64'h00);
    chk("rd1_addr", 64'(we_buf_in[1].read_address), 64'd1);
    tick();
    chk("rd1_early", buf_out.read_data[63:0], 64'd0);
    buf_in.read_tag     = 8'hC0;
    buf_in.read_address = 6'd2;
    we_buf_out[1].read_data = {64{8'hA5}};
    rd_q.push_back({64{8'hA5}});
    #1;
    chk("rd3_vec", 64'({we_buf_in[3].read_valid,
                       we_buf_in[2].read_valid,
                       we_buf_in[1].read_valid,
                       we_buf_in[0].read_valid}), 64'b1000);
    tick();
    pop_rd("rd1_data");
    buf_in.read_valid = 1'b0;
    we_buf_out[1].read_data = '0;
    we_buf_out[3].read_data = {64{8'h5A}};
    rd_q.push_back({64{8'h5A}});
    tick();
    pop_rd("rd3_data");
    we_buf_out[3].read_data = '0;
    tick();
    chk("rd_done", buf_out.read_data[63:0], 64'd0);

    // two credits: third request waits for a return
    we_cmd2[0] = mk(8'h11);
    we_cmd2[1] = mk(8'h12);
    we_cmd2[2] = mk(8'h13);
    #1;
    chk("cr_ack0", 64'(ack2), 64'b0001);
    tag_q.push_back(8'h11);
    tick();
    we_cmd2[0].valid = 1'b0;
    pop_cmd("cr0", cmd_out2);
    #1;
    chk("cr_ack1", 64'(ack2), 64'b0010);
    tag_q.push_back(8'h52);
    tick();
    we_cmd2[1].valid = 1'b0;
    pop_cmd("cr1", cmd_out2);
    #1;
    chk("cr_hold", 64'(ack2), 64'd0);
    tick();
    chk("cr_idle", 64'(cmd_out2.valid), 64'd0);
    rsp2 = '{valid: 1'b1, tag: 8'h11, tag_parity: 1'b1,
             response: 8'h0, credits: 9'd1};
    #1;
    chk("cr_hold2", 64'(ack2), 64'd0);
    tick();
    rsp2.valid = 1'b0;
    chk("cr_idle2", 64'(cmd_out2.valid), 64'd0);
    #1;
    chk("cr_ack2", 64'(ack2), 64'b0100);
    tag_q.push_back(8'h93);
    tick();
    we_cmd2[2].valid = 1'b0;
    pop_cmd("cr2", cmd_out2);

    // oversized return saturates at two credits
    rsp2.valid   = 1'b1;
    rsp2.credits = 9'd50;
    tick();
    rsp2.valid = 1'b0;
    we_cmd2[0] = mk(8'h21);
    we_cmd2[1] = mk(8'h22);
    we_cmd2[2] = mk(8'h23);
    #1;
    chk("sat_ack0", 64'(ack2), 64'b0001);
    tag_q.push_back(8'h21);
    tick();
    we_cmd2[0].valid = 1'b0;
    pop_cmd("sat0", cmd_out2);
    #1;
    chk("sat_ack1", 64'(ack2), 64'b0010);
    tag_q.push_back(8'h62);
    tick();
    we_cmd2[1].valid = 1'b0;
    pop_cmd("sat1", cmd_out2);
    #1;
    chk("sat_hold", 64'(ack2), 64'd0);
    tick();
    we_cmd2 = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
